// File: rtl/regfile_2r1w.sv
// 32 x 32-bit register file, two combinational read ports, one write port, debug read port.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              reg1_re,
    input  logic [ADDR_W-1:0] reg1_addr,
    output logic [DATA_W-1:0] reg1_data,
    input  logic              reg2_re,
    input  logic [ADDR_W-1:0] reg2_addr,
    output logic [DATA_W-1:0] reg2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // No handshake: writes commit in a single cycle and reads are zero-latency,
    // so there is no valid/ready pair and the block never back-pressures.

    // Entry 0 is storage too but is never written, so it stays at its reset value of 0.
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic write_active;
    assign write_active = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_active) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic bypass1;
    logic bypass2;
    assign bypass1 = BYPASS && write_active && (reg1_addr == waddr);
    assign bypass2 = BYPASS && write_active && (reg2_addr == waddr);

    always_comb begin
        reg1_data = '0;
        if (rst || !reg1_re || (reg1_addr == '0)) begin
            reg1_data = '0;
        end else if (bypass1) begin
            reg1_data = wdata;
        end else begin
            reg1_data = regs[reg1_addr];
        end
    end

    always_comb begin
        reg2_data = '0;
        if (rst || !reg2_re || (reg2_addr == '0)) begin
            reg2_data = '0;
        end else if (bypass2) begin
            reg2_data = wdata;
        end else begin
            reg2_data = regs[reg2_addr];
        end
    end

    // Debug port shows committed state only, so it never sees the bypass.
    always_comb begin
        dbg_data = '0;
        if (!rst && (dbg_addr != '0)) begin
            dbg_data = regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed, table-driven bench for regfile_2r1w; expectations follow the
// REGFILE_WRITE_BYPASS_EN define so the same bench covers both builds.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reg1_re;
    logic [4:0]  reg1_addr;
    logic [31:0] reg1_data;
    logic        reg2_re;
    logic [4:0]  reg2_addr;
    logic [31:0] reg2_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks;
    int failures;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_2r1w dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .reg1_re   (reg1_re),
        .reg1_addr (reg1_addr),
        .reg1_data (reg1_data),
        .reg2_re   (reg2_re),
        .reg2_addr (reg2_addr),
        .reg2_data (reg2_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        r1_re;
        logic [4:0]  r1_addr;
        logic        r2_re;
        logic [4:0]  r2_addr;
        logic [4:0]  d_addr;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] expd;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1e, input logic [4:0] r1a,
                         input logic r2e, input logic [4:0] r2a, input logic [4:0] da);
        we = w; waddr = wa; wdata = wd;
        reg1_re = r1e; reg1_addr = r1a;
        reg2_re = r2e; reg2_addr = r2a;
        dbg_addr = da;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // {we, waddr, wdata, r1_re, r1_addr, r2_re, r2_addr, d_addr, exp1, exp2, expd}
        vecs[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd3, 1'b0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7,
                     BYP ? 32'h22222222 : 32'h11111111,
                     BYP ? 32'h22222222 : 32'h11111111, 32'h11111111};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 32'h22222222, 32'h22222222, 32'h22222222};
        vecs[8]  = '{1'b1, 5'd4, 32'h0000000A, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 5'd9, 32'h0000000B, 1'b1, 5'd4, 1'b1, 5'd9, 5'd4,
                     32'h0000000A, BYP ? 32'h0000000B : 32'h0, 32'h0000000A};
        vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd9, 5'd9, 32'h0000000A, 32'h0000000B, 32'h0000000B};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd3, 32'h0000000B, 32'h0000000B, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 32'h0, 32'h22222222, 32'h0};
        vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5, 32'h12345678, 32'h0, 32'h12345678};

        // reset state, with reads enabled so the reset override is exercised
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7, 5'd5);
        #1;
        check("reset_r1", reg1_data, 32'h0);
        check("reset_r2", reg2_data, 32'h0);
        check("reset_dbg", dbg_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_r1", reg1_data, 32'h0);

        // table: drive on negedge, check before the rising edge commits the write
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].r1_re, vecs[i].r1_addr,
                  vecs[i].r2_re, vecs[i].r2_addr, vecs[i].d_addr);
            #1;
            check($sformatf("vec%0d_r1", i), reg1_data, vecs[i].exp1);
            check($sformatf("vec%0d_r2", i), reg2_data, vecs[i].exp2);
            check($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].expd);
        end

        // asynchronous reset between edges with reg[5] = 0x12345678
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
        #1;
        check("pre_async_dbg5", dbg_data, 32'h12345678);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_r1", reg1_data, 32'h0);
        check("async_rst_r2", reg2_data, 32'h0);
        check("async_rst_dbg", dbg_data, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("after_async_dbg5", dbg_data, 32'h0);
        check("after_async_r1_5", reg1_data, 32'h0);
        dbg_addr = 5'd3;
        #1;
        check("after_async_dbg3", dbg_data, 32'h0);

        // reset held across an edge with a write pending: write must be discarded
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 5'd10, 32'h00000055, 1'b1, 5'd10, 1'b0, 5'd0, 5'd10);
        @(posedge clk);
        #1;
        check("rst_write_r1", reg1_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        #1;
        check("rst_write_dropped", dbg_data, 32'h0);
        @(negedge clk);
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("first_write_after_rst", dbg_data, 32'h00000055);
        check("first_write_after_rst_r1", reg1_data, 32'h00000055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
